// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - six-digit multiplexed 7-segment scan driver with anti-ghost blanking
// Optional digit-pair blink enabled by defining SEG7_BLINK_EN.
module seg7_scan_driver #(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 16,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic        CP,
   input  logic        nCR,
   input  logic        En,
   input  logic [23:0] Digits,
   input  logic [1:0]  SetSel,
   output logic [6:0]  Seg,
   output logic        DP,
   output logic [5:0]  AN
);

   localparam int unsigned DW = $clog2(SCAN_DIV);

   logic [DW-1:0] div;
   logic [2:0]    idx;
   logic [3:0]    cur;
   logic          blank;
   logic [5:0]    blink_mask;
   logic [5:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1111110;
         4'd1:    decode = 7'b0110000;
         4'd2:    decode = 7'b1101101;
         4'd3:    decode = 7'b1111001;
         4'd4:    decode = 7'b0110011;
         4'd5:    decode = 7'b1011011;
         4'd6:    decode = 7'b1011111;
         4'd7:    decode = 7'b1110000;
         4'd8:    decode = 7'b1111111;
         4'd9:    decode = 7'b1111011;
         default: decode = 7'b0000001;
      endcase
   endfunction

   always_comb begin
      case (idx)
         3'd0:    cur = Digits[3:0];
         3'd1:    cur = Digits[7:4];
         3'd2:    cur = Digits[11:8];
         3'd3:    cur = Digits[15:12];
         3'd4:    cur = Digits[19:16];
         default: cur = Digits[23:20];
      endcase
   end

`ifdef SEG7_BLINK_EN
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BW-1:0] bcnt;
   logic          phase;

   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (En) begin
         if (32'(bcnt) == BLINK_DIV - 1) begin
            bcnt  <= '0;
            phase <= ~phase;
         end else begin
            bcnt <= bcnt + 1'b1;
         end
      end
   end

   always_comb begin
      blink_mask = 6'b000000;
      if (phase) begin
         case (SetSel)
            2'd1:    blink_mask = 6'b000011;
            2'd2:    blink_mask = 6'b001100;
            2'd3:    blink_mask = 6'b110000;
            default: blink_mask = 6'b000000;
         endcase
      end
   end
`else
   logic unused_setsel;

   assign blink_mask    = 6'b000000;
   assign unused_setsel = ^SetSel;
`endif

   // Leading-zero hours tens and the start-of-slot blank both keep every anode off.
   always_comb begin
      blank   = 32'(div) < BLANK_CYC;
      an_nxt  = 6'b111111;
      if (!blank && !(idx == 3'd5 && Digits[23:20] == 4'd0))
         an_nxt = ~(6'b000001 << idx);
      an_nxt  = an_nxt | blink_mask;
      seg_nxt = decode(cur);
      dp_nxt  = (idx == 3'd2 || idx == 3'd4) && (an_nxt != 6'b111111);
   end

   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         div <= '0;
         idx <= 3'd0;
         AN  <= 6'b111111;
         Seg <= 7'b0000000;
         DP  <= 1'b0;
      end else begin
         AN  <= an_nxt;
         Seg <= seg_nxt;
         DP  <= dp_nxt;
         if (En) begin
            if (div == DW'(SCAN_DIV - 1)) begin
               div <= '0;
               idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
               div <= div + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver against a cycle-count model
module tb_seg7_scan_driver;

   localparam int SD = 4;
   localparam int BC = 1;
   localparam int BD = 8;

   logic        CP = 1'b0;
   logic        nCR;
   logic        En;
   logic [23:0] Digits;
   logic [1:0]  SetSel;
   logic [6:0]  Seg;
   logic        DP;
   logic [5:0]  AN;

   int total = 0;
   int bad   = 0;
   int t     = 0;
   logic [6:0] lut [16];
   logic flag;

   seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
      .CP(CP), .nCR(nCR), .En(En), .Digits(Digits), .SetSel(SetSel),
      .Seg(Seg), .DP(DP), .AN(AN)
   );

   always #5 CP = ~CP;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
      end
   endtask

   // Expected outputs from the number of enabled cycles since reset.
   task automatic model(input int tc, input logic [23:0] d, input logic [1:0] ss,
                        output logic [6:0] es, output logic ed, output logic [5:0] ea);
      int dv, ix;
      logic [3:0] dig;
      dv  = tc % SD;
      ix  = (tc / SD) % 6;
      dig = 4'((d >> (4 * ix)) & 24'hF);
      es  = lut[dig];
      if (dv < BC) ea = 6'h3F;
      else if (ix == 5 && d[23:20] == 4'd0) ea = 6'h3F;
      else ea = ~(6'(1) << ix);
`ifdef SEG7_BLINK_EN
      if (((tc / BD) % 2) == 1 && ss != 2'd0) ea = ea | (6'(3) << (2 * (int'(ss) - 1)));
`endif
      ed = (ix == 2 || ix == 4) && ea != 6'h3F;
   endtask

   task automatic tick();
      logic [6:0] es;
      logic       ed;
      logic [5:0] ea;
      model(t, Digits, SetSel, es, ed, ea);
      @(posedge CP);
      if (En) t++;
      @(negedge CP);
      chk("seg", 32'(Seg), 32'(es));
      chk("dp",  32'(DP),  32'(ed));
      chk("an",  32'(AN),  32'(ea));
   endtask

   // Advance until the registered outputs show slot s at divider position p.
   task automatic run_to(input int s, input int p);
      int n;
      n = 0;
      while (((t - 1) % (SD * 6)) != s * SD + p && n < 200) begin
         tick();
         n++;
      end
      chk("run_to_bound", 32'(n < 200), 32'd1);
   endtask

   initial begin
      lut[0] = 7'b1111110; lut[1] = 7'b0110000; lut[2] = 7'b1101101; lut[3] = 7'b1111001;
      lut[4] = 7'b0110011; lut[5] = 7'b1011011; lut[6] = 7'b1011111; lut[7] = 7'b1110000;
      lut[8] = 7'b1111111; lut[9] = 7'b1111011;
      for (int i = 10; i < 16; i++) lut[i] = 7'b0000001;

      nCR = 1'b0; En = 1'b0; Digits = 24'h0; SetSel = 2'd0;
      repeat (3) @(negedge CP);
      chk("rst_an",  32'(AN),  32'h3F);
      chk("rst_seg", 32'(Seg), 32'h0);
      chk("rst_dp",  32'(DP),  32'h0);

      // Basic scan across two full frames.
      nCR = 1'b1; t = 0; Digits = 24'h123456; En = 1'b1;
      for (int i = 0; i < 48; i++) begin
         tick();
         if (i == 0) chk("first_blank", 32'(AN), 32'h3F);
         if (i == 1) begin
            chk("slot0_an",  32'(AN),  32'b111110);
            chk("slot0_seg", 32'(Seg), 32'b1011111);
         end
         if (i == 9)  chk("slot2_dp", 32'(DP), 32'd1);
         if (i == 13) chk("slot3_dp", 32'(DP), 32'd0);
      end

      // Leading-zero hours tens never lights.
      Digits = 24'h023456;
      flag = 1'b0;
      for (int i = 0; i < 48; i++) begin
         tick();
         if (AN[5] == 1'b0) flag = 1'b1;
      end
      chk("h10_blank", 32'(flag), 32'd0);

      Digits = 24'hA23456;
      run_to(5, 1);
      chk("dash_seg", 32'(Seg), 32'b0000001);
      chk("dash_an",  32'(AN),  32'b011111);

      // Hold in slot 3, live Digits update.
      Digits = 24'h123456;
      run_to(3, 2);
      En = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) Digits = 24'h128456;
         tick();
         chk("hold_an", 32'(AN), 32'b110111);
         if (i == 10) chk("hold_seg_upd", 32'(Seg), 32'b1111111);
      end
      En = 1'b1;
      for (int i = 0; i < 12; i++) tick();

      // Asynchronous reset mid-slot.
      run_to(3, 2);
      #2 nCR = 1'b0;
      #1;
      chk("arst_an",  32'(AN),  32'h3F);
      chk("arst_seg", 32'(Seg), 32'h0);
      chk("arst_dp",  32'(DP),  32'h0);
      @(negedge CP);
      nCR = 1'b1; t = 0;
      tick();
      chk("rel_blank", 32'(AN), 32'h3F);
      tick();
      chk("rel_slot0", 32'(AN), 32'b111110);

      // Minutes pair blink from a clean reset.
      nCR = 1'b0;
      @(negedge CP);
      nCR = 1'b1; t = 0; SetSel = 2'd2;
      flag = 1'b0;
      for (int i = 0; i < 48; i++) begin
         tick();
`ifdef SEG7_BLINK_EN
         if (((t - 1) / BD) % 2 == 1 && AN[3:2] != 2'b11) flag = 1'b1;
`endif
      end
      chk("blink_pair", 32'(flag), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         if (i % 7 == 0) begin
            Digits = 24'($urandom);
            SetSel = 2'($urandom_range(0, 3));
         end
         En = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
